multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 57 +++++
 rtl/instr_decoder.sv | 90 +++++++++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_pkg
// Purpose : Shared definitions for the multicycle control unit: instruction
//           opcode/funct constants, ALU operation codes, FSM state encoding
//           and the decoded instruction class.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Controller states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_IRLOAD = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Instruction class, selects the path through the FSM
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_J       = 3'd1,
    CLS_JAL     = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_ALU     = 3'd4,
    CLS_LW      = 3'd5,
    CLS_SW      = 3'd6
  } iclass_e;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_decoder
// Purpose : Purely combinational decode of the latched instruction fields
//           into an instruction class and the static datapath controls.
// Ports   : opcode_i    - IR[31:26]
//           funct_i     - IR[5:0]
//           rt_i, rd_i  - IR[20:16], IR[15:11]
//           iclass_o    - decoded instruction class (CLS_ILLEGAL if unknown)
//           is_bne_o    - branch polarity (1 = branch when not zero)
//           alu_op_o    - ALU operation code
//           alu_src_o   - 1 selects extended immediate as ALU operand B
//           imm_zext_o  - 1 zero-extends the immediate
//           reg_waddr_o - register-file write address
// Rev     : 1.0  initial release
// ============================================================================
module instr_decoder
  import multicycle_control_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output iclass_e    iclass_o,
  output logic       is_bne_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       imm_zext_o,
  output logic [4:0] reg_waddr_o
);

  always_comb begin
    iclass_o    = CLS_ILLEGAL;
    is_bne_o    = 1'b0;
    alu_op_o    = ALU_ADD;
    alu_src_o   = 1'b0;
    imm_zext_o  = 1'b0;
    reg_waddr_o = rt_i;

    case (opcode_i)
      OP_RTYPE: begin
        reg_waddr_o = rd_i;
        case (funct_i)
          F_ADD: begin iclass_o = CLS_ALU; alu_op_o = ALU_ADD; end
          F_SUB: begin iclass_o = CLS_ALU; alu_op_o = ALU_SUB; end
          F_SLT: begin iclass_o = CLS_ALU; alu_op_o = ALU_SLT; end
          default: iclass_o = CLS_ILLEGAL;
        endcase
      end
      OP_J:   iclass_o = CLS_J;
      OP_JAL: begin
        iclass_o    = CLS_JAL;
        reg_waddr_o = LINK_REG;
      end
      OP_ADDI: begin
        iclass_o  = CLS_ALU;
        alu_src_o = 1'b1;
      end
      OP_XORI: begin
        iclass_o   = CLS_ALU;
        alu_op_o   = ALU_XOR;
        alu_src_o  = 1'b1;
        imm_zext_o = 1'b1;
      end
      OP_LW: begin
        iclass_o  = CLS_LW;
        alu_src_o = 1'b1;
      end
      OP_SW: begin
        iclass_o  = CLS_SW;
        alu_src_o = 1'b1;
      end
      // Branches compare by subtraction; alu_zero then reports equality
      OP_BEQ: begin
        iclass_o = CLS_BRANCH;
        alu_op_o = ALU_SUB;
      end
      OP_BNE: begin
        iclass_o = CLS_BRANCH;
        alu_op_o = ALU_SUB;
        is_bne_o = 1'b1;
      end
      default: iclass_o = CLS_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control
// Purpose : Multicycle controller for a small MIPS-like core. Sequences
//           FETCH/IRLOAD/DECODE/EXEC/MEM/WB, latches the instruction into
//           IR and drives datapath strobes; illegal encodings halt the core.
// Ports   : clk, reset_n         - clock, synchronous active-low reset
//           instr, alu_zero      - fetched instruction, ALU zero flag
//           write_pc             - PC update strobe (one per retired instr)
//           is_branch, is_jump   - next-PC source selects
//           branch_addr,jump_addr- IR immediate / target fields
//           rs, rt, reg_waddr    - register-file addresses
//           reg_we, mem_we       - write strobes
//           alu_src, imm_zext, alu_op - ALU controls
//           mem_to_reg, link     - writeback source selects
//           halted               - illegal instruction seen
//           retired              - completed-instruction counter
// Rev     : 1.0  initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter int         COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  output logic               write_pc,
  output logic               is_branch,
  output logic               is_jump,
  output logic [15:0]        branch_addr,
  output logic [25:0]        jump_addr,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         reg_waddr,
  output logic               reg_we,
  output logic               alu_src,
  output logic               imm_zext,
  output logic [2:0]         alu_op,
  output logic               mem_we,
  output logic               mem_to_reg,
  output logic               link,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [31:0]        ir_q;
  logic [COUNT_W-1:0] retired_q;

  iclass_e            iclass;
  logic               is_bne;

  // Everything below DECODE is driven from IR so that the fetch memory may
  // already present the next word while this instruction completes.
  instr_decoder #(
    .LINK_REG (LINK_REG)
  ) u_instr_decoder (
    .opcode_i    (ir_q[31:26]),
    .funct_i     (ir_q[5:0]),
    .rt_i        (ir_q[20:16]),
    .rd_i        (ir_q[15:11]),
    .iclass_o    (iclass),
    .is_bne_o    (is_bne),
    .alu_op_o    (alu_op),
    .alu_src_o   (alu_src),
    .imm_zext_o  (imm_zext),
    .reg_waddr_o (reg_waddr)
  );

  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign branch_addr = ir_q[15:0];
  assign jump_addr   = ir_q[25:0];
  assign halted      = (state_q == S_HALT);
  assign retired     = retired_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IRLOAD) begin
        ir_q <= instr;
      end
      // write_pc marks the final cycle of every instruction
      if (write_pc) begin
        retired_q <= retired_q + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    write_pc   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_IRLOAD;
      S_IRLOAD: state_d = S_DECODE;
      S_DECODE: begin
        case (iclass)
          CLS_J: begin
            write_pc = 1'b1;
            is_jump  = 1'b1;
            state_d  = S_FETCH;
          end
          CLS_JAL: begin
            write_pc = 1'b1;
            is_jump  = 1'b1;
            reg_we   = 1'b1;
            link     = 1'b1;
            state_d  = S_FETCH;
          end
          CLS_ILLEGAL: state_d = S_HALT;
          default:     state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          CLS_BRANCH: begin
            write_pc  = 1'b1;
            // Only live-input path: the branch decision needs this cycle's compare
            is_branch = is_bne ? ~alu_zero : alu_zero;
            state_d   = S_FETCH;
          end
          CLS_LW, CLS_SW: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (iclass == CLS_SW) begin
          mem_we   = 1'b1;
          write_pc = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        write_pc   = 1'b1;
        mem_to_reg = (iclass == CLS_LW);
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control
// Purpose : Self-checking bench for multicycle_control: directed vector
//           table, hand-written reset/halt sequences and random instruction
//           streams checked against an instruction-level reference model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        alu_zero;
  logic        write_pc, is_branch, is_jump;
  logic [15:0] branch_addr;
  logic [25:0] jump_addr;
  logic [4:0]  rs, rt, reg_waddr;
  logic        reg_we, alu_src, imm_zext, mem_we, mem_to_reg, link, halted;
  logic [2:0]  alu_op;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(
    .LINK_REG (5'd31),
    .COUNT_W  (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .write_pc    (write_pc),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .rs          (rs),
    .rt          (rt),
    .reg_waddr   (reg_waddr),
    .reg_we      (reg_we),
    .alu_src     (alu_src),
    .imm_zext    (imm_zext),
    .alu_op      (alu_op),
    .mem_we      (mem_we),
    .mem_to_reg  (mem_to_reg),
    .link        (link),
    .halted      (halted),
    .retired     (retired)
  );

  // One instruction and everything it is expected to do
  typedef struct packed {
    logic [31:0] word;
    logic        az;
    logic [3:0]  ncyc;   // total cycles (cycles before HALT when ill=1)
    logic        wreg;
    logic [4:0]  waddr;
    logic        wmem;
    logic        jmp;
    logic        br;     // branch taken
    logic        lnk;
    logic        m2r;
    logic [2:0]  aluop;
    logic        asrc;
    logic        zext;
    logic        ill;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;
  vec_t tbl [13];

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  // Instruction-level reference: what an instruction does and how long it takes
  function automatic vec_t model(input logic [31:0] w, input logic az);
    vec_t v;
    logic [5:0] op;
    logic [5:0] fn;
    v = '0;
    v.word = w;
    v.az = az;
    op = w[31:26];
    fn = w[5:0];
    v.waddr = w[20:16];
    case (op)
      6'h00: begin
        v.ncyc = 4'd5; v.wreg = 1'b1; v.waddr = w[15:11];
        if (fn == 6'h20)      v.aluop = 3'd0;
        else if (fn == 6'h22) v.aluop = 3'd1;
        else if (fn == 6'h2A) v.aluop = 3'd3;
        else begin v.ill = 1'b1; v.ncyc = 4'd3; v.wreg = 1'b0; end
      end
      6'h02: begin v.ncyc = 4'd3; v.jmp = 1'b1; end
      6'h03: begin v.ncyc = 4'd3; v.jmp = 1'b1; v.wreg = 1'b1; v.lnk = 1'b1; v.waddr = 5'd31; end
      6'h04: begin v.ncyc = 4'd4; v.br = az;  v.aluop = 3'd1; end
      6'h05: begin v.ncyc = 4'd4; v.br = ~az; v.aluop = 3'd1; end
      6'h08: begin v.ncyc = 4'd5; v.wreg = 1'b1; v.asrc = 1'b1; end
      6'h0E: begin v.ncyc = 4'd5; v.wreg = 1'b1; v.asrc = 1'b1; v.zext = 1'b1; v.aluop = 3'd2; end
      6'h23: begin v.ncyc = 4'd6; v.wreg = 1'b1; v.asrc = 1'b1; v.m2r = 1'b1; end
      6'h2B: begin v.ncyc = 4'd5; v.wmem = 1'b1; v.asrc = 1'b1; end
      default: begin v.ill = 1'b1; v.ncyc = 4'd3; end
    endcase
    return v;
  endfunction

  // Starts at the sampling point of a FETCH cycle, ends at the next one.
  task automatic run_vec(input vec_t v);
    int   last;
    logic fin;
    last = v.ill ? 8 : int'(v.ncyc);
    instr = v.word;
    alu_zero = v.az;
    for (int c = 1; c <= last; c++) begin
      // The fetch port moves on after IRLOAD; decode must ignore it
      if (c >= 3) instr = $urandom;
      fin = !v.ill && (c == int'(v.ncyc));
      chk("write_pc",   c, 32'(write_pc),   32'(fin));
      chk("reg_we",     c, 32'(reg_we),     32'(fin && v.wreg));
      chk("mem_we",     c, 32'(mem_we),     32'(fin && v.wmem));
      chk("is_jump",    c, 32'(is_jump),    32'(fin && v.jmp));
      chk("is_branch",  c, 32'(is_branch),  32'(fin && v.br));
      chk("link",       c, 32'(link),       32'(fin && v.lnk));
      chk("mem_to_reg", c, 32'(mem_to_reg), 32'(fin && v.m2r));
      chk("halted",     c, 32'(halted),     32'(v.ill && c >= 4));
      chk("retired",    c, retired,         32'(exp_retired));
      if (c >= 3) begin
        chk("rs",          c, 32'(rs),          32'(v.word[25:21]));
        chk("rt",          c, 32'(rt),          32'(v.word[20:16]));
        chk("branch_addr", c, 32'(branch_addr), 32'(v.word[15:0]));
        chk("jump_addr",   c, 32'(jump_addr),   32'(v.word[25:0]));
      end
      if (fin && v.wreg) chk("reg_waddr", c, 32'(reg_waddr), 32'(v.waddr));
      if (c == 4 && !v.ill) begin
        chk("alu_op",   c, 32'(alu_op),   32'(v.aluop));
        chk("alu_src",  c, 32'(alu_src),  32'(v.asrc));
        chk("imm_zext", c, 32'(imm_zext), 32'(v.zext));
      end
      @(negedge clk);
    end
    if (!v.ill) exp_retired++;
  endtask

  // Leaves the bench at the sampling point of the first FETCH cycle
  task automatic do_reset();
    reset_n = 1'b0;
    instr = $urandom;
    alu_zero = 1'($urandom);
    @(negedge clk);
    chk("rst_write_pc", 0, 32'(write_pc), 32'd0);
    chk("rst_reg_we",   0, 32'(reg_we),   32'd0);
    chk("rst_mem_we",   0, 32'(mem_we),   32'd0);
    chk("rst_halted",   0, 32'(halted),   32'd0);
    chk("rst_retired",  0, retired,       32'd0);
    chk("rst_ir_rs",    0, 32'(jump_addr), 32'd0);
    reset_n = 1'b1;
    exp_retired = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [4:0]  a, b, d;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] w;
    int          k;

    //          word          az    n     wreg  waddr  wmem  jmp   br    lnk   m2r   aluop asrc  zext  ill
    tbl[0]  = '{32'h00221820, 1'b0, 4'd5, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}; // ADD $3,$1,$2
    tbl[1]  = '{32'h00C72822, 1'b0, 4'd5, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0}; // SUB $5,$6,$7
    tbl[2]  = '{32'h012A402A, 1'b1, 4'd5, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0}; // SLT $8,$9,$10
    tbl[3]  = '{32'h2080FFFF, 1'b0, 4'd5, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}; // ADDI $0,$4,-1
    tbl[4]  = '{32'h39AC00F0, 1'b0, 4'd5, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0}; // XORI $12,$13,0xF0
    tbl[5]  = '{32'h8C220004, 1'b0, 4'd6, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0}; // LW $2,4($1)
    tbl[6]  = '{32'hAC220008, 1'b1, 4'd5, 1'b0, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}; // SW $2,8($1)
    tbl[7]  = '{32'h1000FFFC, 1'b1, 4'd4, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0}; // BEQ taken
    tbl[8]  = '{32'h1000FFFC, 1'b0, 4'd4, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0}; // BEQ not taken
    tbl[9]  = '{32'h1400FFFC, 1'b0, 4'd4, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0}; // BNE taken
    tbl[10] = '{32'h1400FFFC, 1'b1, 4'd4, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0}; // BNE not taken
    tbl[11] = '{32'h08000100, 1'b0, 4'd3, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}; // J
    tbl[12] = '{32'h0C000010, 1'b0, 4'd3, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}; // JAL

    reset_n = 1'b0;
    instr = '0;
    alu_zero = 1'b0;
    do_reset();

    // Directed table
    for (int i = 0; i < 13; i++) run_vec(tbl[i]);
    chk("table_retired", 0, retired, 32'd13);

    // LW then SW back-to-back from reset: two retirements in 11 cycles
    do_reset();
    run_vec(tbl[5]);
    run_vec(tbl[6]);
    chk("lw_sw_retired", 11, retired, 32'd2);

    // Illegal opcode 0x3F halts after DECODE and stays halted
    v = '{32'hFC000000, 1'b0, 4'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    run_vec(v);
    repeat (5) @(negedge clk);
    chk("halt_sticky",  0, 32'(halted),   32'd1);
    chk("halt_retired", 0, retired,       32'd2);
    chk("halt_wpc",     0, 32'(write_pc), 32'd0);
    do_reset();

    // Unsupported R-type funct also halts
    v = '{32'h00221821, 1'b0, 4'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    run_vec(v);
    do_reset();

    // Reset during LW MEM aborts with no writeback
    instr = 32'h8C220004;
    alu_zero = 1'b0;
    repeat (4) @(negedge clk);
    chk("lw_mem_reg_we", 5, 32'(reg_we),   32'd0);
    chk("lw_mem_wpc",    5, 32'(write_pc), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_reg_we",  6, 32'(reg_we),   32'd0);
    chk("abort_wpc",     6, 32'(write_pc), 32'd0);
    chk("abort_mem_we",  6, 32'(mem_we),   32'd0);
    chk("abort_retired", 6, retired,       32'd0);
    reset_n = 1'b1;
    exp_retired = 0;
    run_vec(tbl[0]);
    chk("after_abort_retired", 0, retired, 32'd1);

    // Random legal instruction stream
    for (int n = 0; n < 60; n++) begin
      a  = 5'($urandom);
      b  = 5'($urandom);
      d  = 5'($urandom);
      im = 16'($urandom);
      tg = 26'($urandom);
      k  = $urandom_range(0, 10);
      case (k)
        0:       w = {6'h00, a, b, d, 5'h00, 6'h20};
        1:       w = {6'h00, a, b, d, 5'h00, 6'h22};
        2:       w = {6'h00, a, b, d, 5'h00, 6'h2A};
        3:       w = {6'h08, a, b, im};
        4:       w = {6'h0E, a, b, im};
        5:       w = {6'h23, a, b, im};
        6:       w = {6'h2B, a, b, im};
        7:       w = {6'h04, a, b, im};
        8:       w = {6'h05, a, b, im};
        9:       w = {6'h02, tg};
        default: w = {6'h03, tg};
      endcase
      run_vec(model(w, 1'($urandom)));
    end
    chk("random_retired", 0, retired, 32'd61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
